// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller and its
// timeout counter.
package mem_ctrl_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int CNT_W      = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DROP = 3'd2,
      WAIT_RISE = 3'd3,
      RESP      = 3'd4
   } state_e;

   function automatic logic is_wait(input state_e s);
      return (s == WAIT_DROP) || (s == WAIT_RISE);
   endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating watchdog counter for the mem_ready handshake; raises reached on
// the enabled cycle whose increment lands on TIMEOUT.
module mem_timeout_cnt
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic reached
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Looking one count ahead lets the FSM leave on the very edge the limit is hit,
   // so a stuck memory costs exactly TIMEOUT wait cycles.
   assign reached = en && (cnt_q >= (LIMIT - 1'b1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Bus master between the stack core and the 16-bit data memory: one request at
// a time, tracks the memory's ready drop/rise and returns a one-cycle response.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              mem_w,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   state_e            state_q;
   state_e            state_d;
   logic              mem_w_q;
   logic              mem_w_d;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] mem_wdata_d;
   logic              rsp_valid_q;
   logic              rsp_valid_d;
   logic              rsp_err_q;
   logic              rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [DATA_W-1:0] rsp_rdata_d;

   logic              cnt_en;
   logic              cnt_clr;
   logic              cnt_reached;

   // The counter only runs while the memory has not yet made the expected move.
   assign cnt_en  = ((state_q == WAIT_DROP) &&  mem_ready) ||
                    ((state_q == WAIT_RISE) && !mem_ready);
   assign cnt_clr = !is_wait(state_d);

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .reached (cnt_reached)
   );

   always_comb begin
      state_d     = state_q;
      mem_w_d     = mem_w_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               mem_addr_d  = req_addr;
               mem_wdata_d = req_wdata;
               // A read of the held address gets no ready drop from the memory.
               if (req_we || (req_addr != mem_addr_q)) begin
                  mem_w_d = req_we;
                  state_d = ISSUE;
               end else begin
                  mem_w_d = 1'b0;
                  state_d = WAIT_RISE;
               end
            end
         end

         ISSUE: begin
            mem_w_d = 1'b0;
            state_d = WAIT_DROP;
         end

         WAIT_DROP: begin
            if (!mem_ready) begin
               state_d = WAIT_RISE;
            end else if (cnt_reached) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end

         WAIT_RISE: begin
            if (mem_ready) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = mem_rdata;
            end else if (cnt_reached) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_w_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_w_q     <= mem_w_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_w     = mem_w_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
